i2c_target_engine: RTL

I2C_TARGET_ENGINE -- requirements
Module: i2c_target_engine

---
 rtl/i2c_target_engine.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_engine.sv
// I2C target (slave) protocol engine: 7-bit addressing, byte receive with
// programmable ACK, byte transmit from a ready/valid source; never stretches SCL.
module i2c_target_engine #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [6:0] i_own_addr,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic       i_rx_ack_en,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_addr_match,
    output logic       o_rw,
    output logic       o_busy,
    output logic       o_stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_hist, sda_hist, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data, rx_data_n;
    logic [7:0] tx_byte;
    logic       sda_oe, sda_oe_n;
    logic       rx_valid, rx_valid_n;
    logic       tx_ready, tx_ready_n;
    logic       addr_match, addr_match_n;
    logic       rw, rw_n;
    logic       busy, busy_n;
    logic       stop_pulse, stop_pulse_n;
    logic       addr_hit, load_tx;

    // Synchronizers reset high so a bus parked idle never looks like START/STOP.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = scl_s & sda_hist & ~sda_s;
    assign stop_det  = scl_s & ~sda_hist & sda_s;

    // At the 8th rising edge shift[6:0] already holds address bits [7:1].
    assign addr_hit = (shift[6:0] == i_own_addr);
    assign tx_byte  = i_tx_valid ? i_tx_data : 8'hFF;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In the ACK states bit_cnt is a phase flag: 0 before the driving SCL fall, 1 after it.
    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det && i_enable) begin
            state_next = ADDR;
        end else if (!i_enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:      state_next = IDLE;
                ADDR:      if (scl_rise && bit_cnt == 4'd7)
                               state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  if (scl_fall && bit_cnt == 4'd1)
                               state_next = rw ? TX_BYTE : RX_BYTE;
                RX_BYTE:   if (scl_rise && bit_cnt == 4'd7) state_next = RX_ACK;
                RX_ACK:    if (scl_fall && bit_cnt == 4'd1) state_next = RX_BYTE;
                TX_BYTE:   if (scl_fall && bit_cnt == 4'd8) state_next = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_s)                  state_next = WAIT_STOP;
                    else if (scl_fall && bit_cnt == 4'd1)   state_next = TX_BYTE;
                end
                WAIT_STOP: state_next = WAIT_STOP;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        sda_oe_n     = sda_oe;
        rx_data_n    = rx_data;
        rw_n         = rw;
        busy_n       = busy;
        rx_valid_n   = 1'b0;
        tx_ready_n   = 1'b0;
        addr_match_n = 1'b0;
        stop_pulse_n = 1'b0;
        load_tx      = 1'b0;

        if (stop_det)       busy_n = 1'b0;
        else if (start_det) busy_n = 1'b1;

        if (stop_det) begin
            sda_oe_n     = 1'b0;
            stop_pulse_n = 1'b1;
            bit_cnt_n    = '0;
        end else if (start_det && i_enable) begin
            bit_cnt_n = '0;
        end else if (!i_enable) begin
            sda_oe_n = 1'b0;
        end else begin
            unique case (state)
                ADDR: begin
                    if (scl_fall) sda_oe_n = 1'b0;
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            if (addr_hit) begin
                                addr_match_n = 1'b1;
                                rw_n         = sda_s;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else begin
                            bit_cnt_n = '0;
                            sda_oe_n  = 1'b0;
                            load_tx   = rw;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            rx_data_n  = {shift[6:0], sda_s};
                            rx_valid_n = 1'b1;
                            bit_cnt_n  = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n  = i_rx_ack_en;
                            bit_cnt_n = 4'd1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                        end else begin
                            shift_n  = {shift[6:0], 1'b1};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !sda_s) begin
                        bit_cnt_n = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_n = '0;
                        load_tx   = 1'b1;
                    end
                end
                IDLE, WAIT_STOP: sda_oe_n = 1'b0;
                default:         sda_oe_n = 1'b0;
            endcase
        end

        if (load_tx) begin
            shift_n    = tx_byte;
            sda_oe_n   = ~tx_byte[7];
            tx_ready_n = i_tx_valid;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            addr_match <= 1'b0;
            rw         <= 1'b0;
            busy       <= 1'b0;
            stop_pulse <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            sda_oe     <= sda_oe_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            tx_ready   <= tx_ready_n;
            addr_match <= addr_match_n;
            rw         <= rw_n;
            busy       <= busy_n;
            stop_pulse <= stop_pulse_n;
        end
    end

    assign o_sda_oe     = sda_oe;
    assign o_tx_ready   = tx_ready;
    assign o_rx_data    = rx_data;
    assign o_rx_valid   = rx_valid;
    assign o_addr_match = addr_match;
    assign o_rw         = rw;
    assign o_busy       = busy;
    assign o_stop_det   = stop_pulse;

endmodule
